// File: rtl/pipelined_subtractor_pkg.sv
// Shared definitions for the two-stage pipelined subtractor.
package pipelined_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 7;
    localparam int MAX_WIDTH     = 64;

    // Carry out of an n-bit propagate/generate chain for a given carry-in.
    function automatic logic pg_carry_out(
        input logic [MAX_WIDTH-1:0] p,
        input logic [MAX_WIDTH-1:0] g,
        input logic                 cin,
        input int                   n
    );
        logic c;
        c = cin;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < n) begin
                c = g[i] | (p[i] & c);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pipelined_subtractor_pg_prefix_chain.sv
// Propagate/generate carry chain: per-bit carry-in values plus the final carry.
module pg_prefix_chain
    import pipelined_subtractor_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_p,
    input  logic [N-1:0] i_g,
    input  logic         i_cin,
    output logic [N-1:0] o_carry,
    output logic         o_cout
);

    // w_c[i] is the carry entering bit i.
    logic [N-1:0]           w_c;
    logic [MAX_WIDTH-1:0]   w_p_ext;
    logic [MAX_WIDTH-1:0]   w_g_ext;

    assign w_c[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_carry
            assign w_c[gi+1] = i_g[gi] | (i_p[gi] & w_c[gi]);
        end
    endgenerate

    assign o_carry = w_c;

    // Final carry comes from the shared helper so both halves agree on the rule.
    assign w_p_ext = MAX_WIDTH'(i_p);
    assign w_g_ext = MAX_WIDTH'(i_g);
    assign o_cout  = pg_carry_out(w_p_ext, w_g_ext, i_cin, N);

endmodule

// File: rtl/pipelined_subtractor.sv
// Two-stage registered subtractor (a - b) on a valid/ready stream.
// Stage 1 resolves the low LO_W bits, stage 2 the high bits plus flags.
module pipelined_subtractor
    import pipelined_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HI_W = WIDTH - LO_W;

    // Handshake
    logic w_adv1;
    logic w_adv2;
    logic w_in_fire;

    // Stage 1 combinational
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [LO_W-1:0]  w_lo_carry;
    logic             w_lo_cout;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [LO_W-1:0]  r_s1_lo_diff;
    logic             r_s1_carry;
    logic [HI_W-1:0]  r_s1_hi_p;
    logic [HI_W-1:0]  r_s1_hi_g;
    logic             r_s1_a_msb;
    logic             r_s1_b_msb;

    // Stage 2 combinational
    logic [HI_W-1:0]  w_hi_carry;
    logic             w_hi_cout;
    logic [HI_W-1:0]  w_hi_diff;
    logic             w_ovf;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    // A stage may advance when the stage downstream of it is free or draining.
    assign w_adv2    = !r_s2_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign in_ready  = w_adv1;
    assign w_in_fire = in_valid && w_adv1;

    // Subtraction as a + ~b + 1.
    assign w_p = a ^ ~b;
    assign w_g = a & ~b;

    pg_prefix_chain #(.N(LO_W)) u_lo_chain (
        .i_p     (w_p[LO_W-1:0]),
        .i_g     (w_g[LO_W-1:0]),
        .i_cin   (1'b1),
        .o_carry (w_lo_carry),
        .o_cout  (w_lo_cout)
    );

    // Stage 1: capture resolved low bits and the raw high-half p/g.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_lo_diff <= '0;
            r_s1_carry   <= 1'b0;
            r_s1_hi_p    <= '0;
            r_s1_hi_g    <= '0;
            r_s1_a_msb   <= 1'b0;
            r_s1_b_msb   <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_lo_diff <= w_p[LO_W-1:0] ^ w_lo_carry;
                r_s1_carry   <= w_lo_cout;
                r_s1_hi_p    <= w_p[WIDTH-1:LO_W];
                r_s1_hi_g    <= w_g[WIDTH-1:LO_W];
                r_s1_a_msb   <= a[WIDTH-1];
                r_s1_b_msb   <= b[WIDTH-1];
            end
        end
    end

    pg_prefix_chain #(.N(HI_W)) u_hi_chain (
        .i_p     (r_s1_hi_p),
        .i_g     (r_s1_hi_g),
        .i_cin   (r_s1_carry),
        .o_carry (w_hi_carry),
        .o_cout  (w_hi_cout)
    );

    assign w_hi_diff = r_s1_hi_p ^ w_hi_carry;
    assign w_ovf     = (r_s1_a_msb ^ r_s1_b_msb) & (w_hi_diff[HI_W-1] ^ r_s1_a_msb);

    // Stage 2: finish the high half; data only moves when a real result arrives,
    // so the output reads zero after reset until the first result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= {w_hi_diff, r_s1_lo_diff};
                r_bout <= ~w_hi_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    // Masked during reset so no result leaves in the reset cycle.
    assign out_valid = r_s2_valid && !rst;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench: WIDTH=7 and WIDTH=2 instances against an arithmetic model.
module tb_pipelined_subtractor;

    logic clk;

    // WIDTH=7 instance
    logic       rst;
    logic       in_valid7, in_ready7, out_valid7, out_ready7;
    logic [6:0] a7, b7, diff7;
    logic       bout7, ovf7;

    // WIDTH=2 instance
    logic       rst2;
    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0] a2, b2, diff2;
    logic       bout2, ovf2;

    int checks = 0;
    int errors = 0;
    int npop7  = 0;
    int npop2  = 0;
    bit done2  = 0;

    logic [8:0]  sb7_exp[$];
    logic [13:0] sb7_ab[$];
    logic [3:0]  sb2_exp[$];
    bit          hold7_pending = 0;
    logic [8:0]  hold7_val;
    bit          hold2_pending = 0;
    logic [3:0]  hold2_val;

    pipelined_subtractor #(.WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7),
        .a(a7), .b(b7), .out_valid(out_valid7), .out_ready(out_ready7),
        .diff(diff7), .bout(bout7), .ovf(ovf7)
    );

    pipelined_subtractor #(.WIDTH(2), .LO_W(1)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .diff(diff2), .bout(bout2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {bout, ovf, diff[63:0]} from plain integer arithmetic.
    function automatic logic [65:0] ref_sub(input longint unsigned av, input longint unsigned bv, input int w);
        longint unsigned m, ua, ub;
        longint          half, sa, sbv, sd;
        logic [65:0]     r;
        m    = (64'd1 << w) - 64'd1;
        ua   = av & m;
        ub   = bv & m;
        half = longint'(64'd1 << (w - 1));
        sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sbv  = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
        sd   = sa - sbv;
        r[63:0] = (ua - ub) & m;
        r[64]   = (sd >= half) || (sd < -half);
        r[65]   = ua < ub;
        return r;
    endfunction

    function automatic logic [8:0] exp7(input logic [6:0] av, input logic [6:0] bv);
        logic [65:0] r;
        r = ref_sub(64'(av), 64'(bv), 7);
        return {r[65], r[64], r[6:0]};
    endfunction

    function automatic logic [3:0] exp2(input logic [1:0] av, input logic [1:0] bv);
        logic [65:0] r;
        r = ref_sub(64'(av), 64'(bv), 2);
        return {r[65], r[64], r[1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // One cycle on the WIDTH=7 instance: drive at negedge, evaluate transfers just after.
    task automatic step7(input logic v, input logic [6:0] av, input logic [6:0] bv,
                         input logic ordy, input logic r, output logic acc);
        logic [8:0]  e;
        logic [13:0] ab;
        @(negedge clk);
        rst = r; in_valid7 = v; a7 = av; b7 = bv; out_ready7 = ordy;
        #1;
        acc = 1'b0;
        if (r) begin
            sb7_exp.delete();
            sb7_ab.delete();
            hold7_pending = 0;
        end else begin
            if (hold7_pending) begin
                chk("w7_hold_valid", 64'(out_valid7), 64'd1);
                chk("w7_hold_data", 64'({bout7, ovf7, diff7}), 64'(hold7_val));
            end
            hold7_pending = out_valid7 && !ordy;
            hold7_val     = {bout7, ovf7, diff7};
            if (out_valid7 && ordy) begin
                if (sb7_exp.size() == 0) begin
                    chk("w7_unexpected_out", 64'(out_valid7), 64'd0);
                end else begin
                    e  = sb7_exp.pop_front();
                    ab = sb7_ab.pop_front();
                    chk("w7_result", 64'({bout7, ovf7, diff7}), 64'(e));
                    npop7++;
                    $display("w7 txn a=%h b=%h diff=%h bout=%b ovf=%b", ab[13:7], ab[6:0], diff7, bout7, ovf7);
                end
            end
            if (v && in_ready7) begin
                sb7_exp.push_back(exp7(av, bv));
                sb7_ab.push_back({av, bv});
                acc = 1'b1;
            end
        end
    endtask

    task automatic step2(input logic v, input logic [1:0] av, input logic [1:0] bv,
                         input logic ordy, input logic r, output logic acc);
        logic [3:0] e;
        @(negedge clk);
        rst2 = r; in_valid2 = v; a2 = av; b2 = bv; out_ready2 = ordy;
        #1;
        acc = 1'b0;
        if (r) begin
            sb2_exp.delete();
            hold2_pending = 0;
        end else begin
            if (hold2_pending) begin
                chk("w2_hold_data", 64'({out_valid2, bout2, ovf2, diff2}), 64'({1'b1, hold2_val}));
            end
            hold2_pending = out_valid2 && !ordy;
            hold2_val     = {bout2, ovf2, diff2};
            if (out_valid2 && ordy) begin
                if (sb2_exp.size() == 0) begin
                    chk("w2_unexpected_out", 64'(out_valid2), 64'd0);
                end else begin
                    e = sb2_exp.pop_front();
                    chk("w2_result", 64'({bout2, ovf2, diff2}), 64'(e));
                    npop2++;
                    $display("w2 txn diff=%h bout=%b ovf=%b", diff2, bout2, ovf2);
                end
            end
            if (v && in_ready2) begin
                sb2_exp.push_back(exp2(av, bv));
                acc = 1'b1;
            end
        end
    endtask

    task automatic drain7();
        logic acc;
        for (int i = 0; i < 40; i++) begin
            if (sb7_exp.size() == 0 && !out_valid7) break;
            step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, acc);
        end
        chk("w7_drain_empty", 64'(sb7_exp.size()), 64'd0);
    endtask

    // Watchdog: never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // WIDTH=2 instance: reset, then every pair four times with random handshakes.
    initial begin
        logic acc;
        int   idx;
        int   guard;
        rst2 = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b0;
        step2(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, acc);
        step2(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, acc);
        step2(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, acc);
        chk("w2_reset_state", 64'({out_valid2, bout2, ovf2, diff2, in_ready2}), 64'h01);
        idx = 0;
        guard = 0;
        while (idx < 64 && guard < 2000) begin
            step2(($urandom % 4) != 0, idx[3:2], idx[1:0], ($urandom % 3) != 0, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        for (int i = 0; i < 20; i++) begin
            if (sb2_exp.size() == 0 && !out_valid2) break;
            step2(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, acc);
        end
        chk("w2_sweep_count", 64'(npop2), 64'd64);
        done2 = 1;
    end

    // WIDTH=7 instance: directed cases, backpressure, reset mid-stream, full sweep.
    initial begin
        logic       acc;
        logic [6:0] da[4];
        logic [6:0] db[4];
        int         k, base, idx, guard;

        rst = 1'b1; in_valid7 = 1'b0; a7 = '0; b7 = '0; out_ready7 = 1'b0;

        // Model pinned to hand-worked values
        chk("model_5_3",   64'(exp7(7'h05, 7'h03)), 64'h002);
        chk("model_3_5",   64'(exp7(7'h03, 7'h05)), 64'h17E);
        chk("model_0_1",   64'(exp7(7'h00, 7'h01)), 64'h17F);
        chk("model_40_01", 64'(exp7(7'h40, 7'h01)), 64'h0BF);
        chk("model_3F_7F", 64'(exp7(7'h3F, 7'h7F)), 64'h1C0);
        chk("model_eq",    64'(exp7(7'h55, 7'h55)), 64'h000);

        step7(1'b0, 7'd0, 7'd0, 1'b0, 1'b1, acc);
        step7(1'b0, 7'd0, 7'd0, 1'b0, 1'b1, acc);
        step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, acc);
        chk("w7_reset_out_valid", 64'(out_valid7), 64'd0);
        chk("w7_reset_data", 64'({bout7, ovf7, diff7}), 64'd0);
        chk("w7_reset_in_ready", 64'(in_ready7), 64'd1);

        // Latency: 5-3 appears exactly two cycles after acceptance
        step7(1'b1, 7'h05, 7'h03, 1'b1, 1'b0, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, acc);
        chk("lat_cycle1_valid", 64'(out_valid7), 64'd0);
        step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, acc);
        chk("lat_cycle2_valid", 64'(out_valid7), 64'd1);
        chk("lat_diff", 64'({bout7, ovf7, diff7}), 64'h002);
        drain7();

        // Directed boundary operands, back-to-back
        da = '{7'h03, 7'h00, 7'h40, 7'h3F};
        db = '{7'h05, 7'h01, 7'h01, 7'h7F};
        k = 0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            step7(1'b1, da[k], db[k], 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        chk("directed_accepts", 64'(k), 64'd4);
        drain7();

        // Backpressure: four pairs offered while the sink is stalled
        base = npop7;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step7(1'b1, da[k], db[k], 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_accepts_stalled", 64'(k), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready7), 64'd0);
        for (int i = 0; i < 30; i++) begin
            if (k >= 4 && sb7_exp.size() == 0 && !out_valid7) break;
            step7(k < 4, da[k % 4], db[k % 4], 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_results_out", 64'(npop7 - base), 64'd4);

        // Reset with both stages full discards everything in flight
        step7(1'b1, 7'h11, 7'h22, 1'b0, 1'b0, acc);
        step7(1'b1, 7'h33, 7'h44, 1'b0, 1'b0, acc);
        step7(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, acc);
        chk("rst_full_in_ready", 64'(in_ready7), 64'd0);
        step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b1, acc);
        chk("rst_cycle_out_valid", 64'(out_valid7), 64'd0);
        step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, acc);
        chk("rst_after_out_valid", 64'(out_valid7), 64'd0);
        chk("rst_after_data", 64'({bout7, ovf7, diff7}), 64'd0);
        chk("rst_after_in_ready", 64'(in_ready7), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step7(1'b0, 7'd0, 7'd0, 1'b1, 1'b0, acc);
            chk("rst_no_stale_out", 64'(out_valid7), 64'd0);
        end

        // Exhaustive sweep with random handshakes
        base = npop7;
        idx = 0;
        guard = 0;
        while (idx < 16384 && guard < 60000) begin
            step7(($urandom % 4) != 0, idx[13:7], idx[6:0], ($urandom % 4) != 0, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        drain7();
        chk("sweep_count", 64'(npop7 - base), 64'd16384);

        for (int i = 0; i < 3000 && !done2; i++) @(negedge clk);
        chk("w2_done", 64'(done2), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
